// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mc_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StExecR,
    StExecI,
    StExecAdr,
    StMemRd,
    StMemWr,
    StWbR,
    StWbI,
    StWbMem,
    StExecBr,
    StJump,
    StTrap
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OpR     = 6'b000000;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  // Function codes (IR[5:0]) for R-type
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnSlt  = 6'b101010;
  localparam logic [5:0] FnJr   = 6'b001000;

  // ALU operations
  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b100;
  localparam logic [2:0] AluLui = 3'b101;

  // Next-PC select
  localparam logic [1:0] SPc4  = 2'b00;
  localparam logic [1:0] SBeq  = 2'b01;
  localparam logic [1:0] SJump = 2'b10;
  localparam logic [1:0] SJr   = 2'b11;

  // State that follows DECODE for a given op/funct; anything unknown traps.
  function automatic state_e decode_next(input logic [5:0] op, input logic [5:0] funct);
    state_e nxt;
    nxt = StTrap;
    case (op)
      OpR: begin
        case (funct)
          FnAddu, FnSubu, FnAnd, FnOr, FnSlt: nxt = StExecR;
          FnJr:                               nxt = StJump;
          default:                            nxt = StTrap;
        endcase
      end
      OpAddiu, OpOri, OpLui: nxt = StExecI;
      OpLw, OpSw:            nxt = StExecAdr;
      OpBeq:                 nxt = StExecBr;
      OpJ, OpJal:            nxt = StJump;
      default:               nxt = StTrap;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive unacknowledged request cycles and flags the timeout cycle.
module mc_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic ack,
  output logic timeout
);

  localparam logic [7:0] Limit = 8'(MAX_WAIT - 1);

  logic [7:0] wait_q;

  // Count only while a request is pending without ack; any ack or idle cycle restarts it.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_q <= '0;
    end else if (active && !ack) begin
      wait_q <= wait_q + 8'd1;
    end else begin
      wait_q <= '0;
    end
  end

  // Fires on the MAX_WAIT-th waiting cycle; a same-cycle ack suppresses it.
  assign timeout = active && !ack && (wait_q == Limit);

endmodule

// File: rtl/mc_ctrl_ws.sv
// Multi-cycle MIPS control unit with req/ack memory waits, trap and perf counters.
module mc_ctrl_ws
  import mc_pkg::*;
#(
  parameter int unsigned MAX_WAIT  = 15,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 imem_ack,
  input  logic                 dmem_ack,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 a_write,
  output logic                 b_write,
  output logic                 c_write,
  output logic                 reg_write,
  output logic                 regdst,
  output logic                 extop,
  output logic                 alusrc,
  output logic                 memread,
  output logic                 memwrite,
  output logic                 r31,
  output logic [2:0]           aluop,
  output logic [1:0]           s,
  output logic                 trap,
  output logic [CNT_WIDTH-1:0] instret,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] instret_q, stall_q;
  logic                 waiting, cur_ack, timeout, stall;

  assign waiting = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  assign cur_ack = (state_q == StFetch) ? imem_ack : dmem_ack;
  assign stall   = waiting && !cur_ack;

  mc_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clock  (clock),
    .reset  (reset),
    .active (waiting),
    .ack    (cur_ack),
    .timeout(timeout)
  );

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (imem_ack)     state_d = StDecode;
        else if (timeout) state_d = StTrap;
      end
      StDecode:  state_d = decode_next(op, funct);
      StExecR:   state_d = StWbR;
      StExecI:   state_d = StWbI;
      StExecAdr: state_d = (op == OpLw) ? StMemRd : StMemWr;
      StMemRd: begin
        if (dmem_ack)     state_d = StWbMem;
        else if (timeout) state_d = StTrap;
      end
      StMemWr: begin
        if (dmem_ack)     state_d = StFetch;
        else if (timeout) state_d = StTrap;
      end
      StWbR, StWbI, StWbMem, StExecBr, StJump: state_d = StFetch;
      StTrap:  state_d = StTrap;
      default: state_d = StTrap;
    endcase
  end

  // State register and counters; pc_write marks the single retiring cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StFetch;
      instret_q <= '0;
      stall_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pc_write) instret_q <= instret_q + CNT_WIDTH'(1);
      if (stall)    stall_q   <= stall_q + CNT_WIDTH'(1);
    end
  end

  assign instret   = instret_q;
  assign stall_cnt = stall_q;

  // Output decode from state plus op/funct; forced quiet while reset is held.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    a_write   = 1'b0;
    b_write   = 1'b0;
    c_write   = 1'b0;
    reg_write = 1'b0;
    regdst    = 1'b0;
    extop     = 1'b0;
    alusrc    = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    r31       = 1'b0;
    aluop     = AluAdd;
    s         = SPc4;
    trap      = 1'b0;
    if (!reset) begin
      case (state_q)
        StFetch: begin
          imem_req = 1'b1;
          ir_write = imem_ack;
        end
        StDecode: begin
          a_write = 1'b1;
          b_write = 1'b1;
        end
        StExecR: begin
          c_write = 1'b1;
          case (funct)
            FnSubu:  aluop = AluSub;
            FnAnd:   aluop = AluAnd;
            FnOr:    aluop = AluOr;
            FnSlt:   aluop = AluSlt;
            default: aluop = AluAdd;
          endcase
        end
        StExecI: begin
          c_write = 1'b1;
          alusrc  = 1'b1;
          extop   = (op == OpAddiu);
          case (op)
            OpOri:   aluop = AluOr;
            OpLui:   aluop = AluLui;
            default: aluop = AluAdd;
          endcase
        end
        StExecAdr: begin
          c_write = 1'b1;
          alusrc  = 1'b1;
          extop   = 1'b1;
        end
        StMemRd: begin
          dmem_req = 1'b1;
          memread  = 1'b1;
        end
        StMemWr: begin
          dmem_req = 1'b1;
          memwrite = 1'b1;
          pc_write = dmem_ack;
        end
        StWbR: begin
          reg_write = 1'b1;
          regdst    = 1'b1;
          pc_write  = 1'b1;
        end
        StWbI: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
        end
        StWbMem: begin
          reg_write = 1'b1;
          memread   = 1'b1;
          pc_write  = 1'b1;
        end
        StExecBr: begin
          aluop    = AluSub;
          pc_write = 1'b1;
          s        = SBeq;
        end
        StJump: begin
          pc_write  = 1'b1;
          s         = (op == OpR) ? SJr : SJump;
          reg_write = (op == OpJal);
          r31       = (op == OpJal);
        end
        StTrap:  trap = 1'b1;
        default: trap = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_ws.sv
// Directed bench for mc_ctrl_ws with MAX_WAIT=4.
module tb_mc_ctrl_ws;

  logic        clock, reset;
  logic [5:0]  op, funct;
  logic        imem_ack, dmem_ack;
  logic        imem_req, dmem_req, pc_write, ir_write, a_write, b_write, c_write, reg_write;
  logic        regdst, extop, alusrc, memread, memwrite, r31, trap;
  logic [2:0]  aluop;
  logic [1:0]  s;
  logic [31:0] instret, stall_cnt;

  int checks   = 0;
  int failures = 0;

  mc_ctrl_ws #(
    .MAX_WAIT (4),
    .CNT_WIDTH(32)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .op       (op),
    .funct    (funct),
    .imem_ack (imem_ack),
    .dmem_ack (dmem_ack),
    .imem_req (imem_req),
    .dmem_req (dmem_req),
    .pc_write (pc_write),
    .ir_write (ir_write),
    .a_write  (a_write),
    .b_write  (b_write),
    .c_write  (c_write),
    .reg_write(reg_write),
    .regdst   (regdst),
    .extop    (extop),
    .alusrc   (alusrc),
    .memread  (memread),
    .memwrite (memwrite),
    .r31      (r31),
    .aluop    (aluop),
    .s        (s),
    .trap     (trap),
    .instret  (instret),
    .stall_cnt(stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [19:0] outs;
  assign outs = {imem_req, dmem_req, pc_write, ir_write, a_write, b_write, c_write, reg_write,
                 regdst, extop, alusrc, memread, memwrite, r31, aluop, s, trap};

  // en groups: {imem_req dmem_req}_{pc_write ir_write a_write b_write}
  //            _{c_write reg_write regdst extop}_{alusrc memread memwrite r31}
  function automatic logic [19:0] mk(input logic [13:0] en, input logic [2:0] alu,
                                     input logic [1:0] sv, input logic tr);
    return {en, alu, sv, tr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next sampling window (just after the falling edge).
  task automatic nxt();
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; op = 6'b000000; funct = 6'b100001; imem_ack = 1'b0; dmem_ack = 1'b0;

    // Reset state
    @(negedge clock); @(negedge clock); #1;
    chk("reset_outs", 32'(outs), 32'(mk(14'b00_0000_0000_0000, 3'b000, 2'b00, 1'b0)));
    chk("reset_instret", instret, 32'd0);
    chk("reset_stall", stall_cnt, 32'd0);

    // Zero-wait addu
    do_reset(); op = 6'b000000; funct = 6'b100001; imem_ack = 1'b1; dmem_ack = 1'b1; #1;
    chk("addu_fetch", 32'(outs), 32'(mk(14'b10_0100_0000_0000, 3'b000, 2'b00, 1'b0)));
    nxt(); #1;
    chk("addu_decode", 32'(outs), 32'(mk(14'b00_0011_0000_0000, 3'b000, 2'b00, 1'b0)));
    nxt(); #1;
    chk("addu_exec", 32'(outs), 32'(mk(14'b00_0000_1000_0000, 3'b000, 2'b00, 1'b0)));
    nxt(); #1;
    chk("addu_wb", 32'(outs), 32'(mk(14'b00_1000_0110_0000, 3'b000, 2'b00, 1'b0)));
    nxt(); #1;
    chk("addu_instret", instret, 32'd1);
    chk("addu_stall", stall_cnt, 32'd0);

    // subu decode path: ALU op follows funct
    do_reset(); funct = 6'b100011; #1;
    nxt(); #1; nxt(); #1;
    chk("subu_exec", 32'(outs), 32'(mk(14'b00_0000_1000_0000, 3'b001, 2'b00, 1'b0)));

    // lw with dmem_ack after 3 waiting cycles
    do_reset(); op = 6'b100011; imem_ack = 1'b1; dmem_ack = 1'b0; #1;
    nxt(); #1;
    nxt(); #1;
    chk("lw_exec_adr", 32'(outs), 32'(mk(14'b00_0000_1001_1000, 3'b000, 2'b00, 1'b0)));
    for (int i = 0; i < 4; i++) begin
      nxt(); dmem_ack = (i == 3); #1;
      chk("lw_mem_rd", 32'(outs), 32'(mk(14'b01_0000_0000_0100, 3'b000, 2'b00, 1'b0)));
    end
    nxt(); dmem_ack = 1'b0; #1;
    chk("lw_wb_mem", 32'(outs), 32'(mk(14'b00_1000_0100_0100, 3'b000, 2'b00, 1'b0)));
    nxt(); #1;
    chk("lw_instret", instret, 32'd1);
    chk("lw_stall", stall_cnt, 32'd3);

    // sw (one wait cycle) then jal
    do_reset(); op = 6'b101011; imem_ack = 1'b1; dmem_ack = 1'b0; #1;
    nxt(); #1; nxt(); #1;
    nxt(); #1;
    chk("sw_wait", 32'(outs), 32'(mk(14'b01_0000_0000_0010, 3'b000, 2'b00, 1'b0)));
    nxt(); dmem_ack = 1'b1; #1;
    chk("sw_ack", 32'(outs), 32'(mk(14'b01_1000_0000_0010, 3'b000, 2'b00, 1'b0)));
    nxt(); dmem_ack = 1'b0; op = 6'b000011; #1;
    chk("jal_fetch", 32'(outs), 32'(mk(14'b10_0100_0000_0000, 3'b000, 2'b00, 1'b0)));
    nxt(); #1;
    nxt(); #1;
    chk("jal_jump", 32'(outs), 32'(mk(14'b00_1000_0100_0001, 3'b000, 2'b10, 1'b0)));
    nxt(); #1;
    chk("swjal_instret", instret, 32'd2);
    chk("swjal_stall", stall_cnt, 32'd1);

    // imem_ack never arrives: trap after the 4th waiting cycle
    do_reset(); op = 6'b000000; funct = 6'b100001; imem_ack = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin nxt(); #1; end
      chk("to_fetch_wait", 32'(outs), 32'(mk(14'b10_0000_0000_0000, 3'b000, 2'b00, 1'b0)));
    end
    nxt(); #1;
    chk("to_trap", 32'(outs), 32'(mk(14'b00_0000_0000_0000, 3'b000, 2'b00, 1'b1)));
    chk("to_stall", stall_cnt, 32'd4);
    nxt(); imem_ack = 1'b1; #1;
    chk("to_trap_sticky", 32'(outs), 32'(mk(14'b00_0000_0000_0000, 3'b000, 2'b00, 1'b1)));
    nxt(); #1;
    chk("to_instret", instret, 32'd0);
    do_reset(); imem_ack = 1'b0; #1;
    chk("to_reset_clear", 32'(outs), 32'(mk(14'b10_0000_0000_0000, 3'b000, 2'b00, 1'b0)));

    // Ack on exactly the MAX_WAIT-th waiting cycle wins over the timeout
    do_reset(); imem_ack = 1'b0; #1;
    nxt(); #1; nxt(); #1;
    nxt(); imem_ack = 1'b1; #1;
    chk("race_fetch", 32'(outs), 32'(mk(14'b10_0100_0000_0000, 3'b000, 2'b00, 1'b0)));
    nxt(); #1;
    chk("race_decode", 32'(outs), 32'(mk(14'b00_0011_0000_0000, 3'b000, 2'b00, 1'b0)));
    nxt(); #1; nxt(); #1;
    chk("race_wb", 32'(outs), 32'(mk(14'b00_1000_0110_0000, 3'b000, 2'b00, 1'b0)));
    nxt(); #1;
    chk("race_instret", instret, 32'd1);
    chk("race_stall", stall_cnt, 32'd3);

    // Illegal opcode traps after DECODE
    do_reset(); op = 6'b111111; imem_ack = 1'b1; #1;
    nxt(); #1;
    nxt(); #1;
    chk("ill_trap", 32'(outs), 32'(mk(14'b00_0000_0000_0000, 3'b000, 2'b00, 1'b1)));
    nxt(); #1;
    chk("ill_sticky", 32'(outs), 32'(mk(14'b00_0000_0000_0000, 3'b000, 2'b00, 1'b1)));
    chk("ill_instret", instret, 32'd0);

    // Reset asserted while waiting in MEM_RD
    do_reset(); op = 6'b100011; imem_ack = 1'b1; dmem_ack = 1'b0; #1;
    nxt(); #1; nxt(); #1;
    nxt(); #1;
    chk("rst_mem_rd", 32'(outs), 32'(mk(14'b01_0000_0000_0100, 3'b000, 2'b00, 1'b0)));
    nxt(); reset = 1'b1; #1;
    chk("rst_held", 32'(outs), 32'(mk(14'b00_0000_0000_0000, 3'b000, 2'b00, 1'b0)));
    nxt(); reset = 1'b0; imem_ack = 1'b0; #1;
    chk("rst_fetch", 32'(outs), 32'(mk(14'b10_0000_0000_0000, 3'b000, 2'b00, 1'b0)));
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_instret", instret, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
